// File: rtl/instruction_mem.sv
// Instruction memory for the 19-bit CPU fetch stage: combinational read,
// synchronous program-load write, asynchronous reload of the boot image.
module instruction_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 19,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instruction,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [31:0]       pc_ext;
    logic [31:0]       wr_addr_ext;
    logic              pc_in_range;
    logic              wr_in_range;

    function automatic logic [DATA_W-1:0] boot_word(input int idx);
        logic [DATA_W-1:0] w;
        case (idx)
            0:       w = DATA_W'(19'h08123);
            1:       w = DATA_W'(19'h10456);
            2:       w = DATA_W'(19'h18789);
            3:       w = DATA_W'(19'h7FFFF);
            default: w = '0;
        endcase
        return w;
    endfunction

    assign pc_ext      = 32'(pc);
    assign wr_addr_ext = 32'(wr_addr);
    assign pc_in_range = (pc_ext < 32'(DEPTH));
    assign wr_in_range = (wr_addr_ext < 32'(DEPTH));

    // Reset reloads every word, so contents never carry X after the first reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= boot_word(i);
            end
        end else if (wr_en && wr_in_range) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Out-of-range fetches return a NOP rather than aliasing into the array.
    always_comb begin
        instruction = '0;
        if (pc_in_range) begin
            instruction = mem_q[pc];
        end
    end

endmodule

// File: tb/tb_instruction_mem.sv
// Self-checking bench for instruction_mem: directed plan plus randomized
// writes, reads and reset pulses against an array reference model.
module tb_instruction_mem;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 19;
    localparam int DEPTH  = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instruction;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] model [DEPTH];
    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    instruction_mem #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .instruction(instruction),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %05h expected %05h", tag, obs, exp);
        end
    endtask

    task automatic model_boot();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        model[0] = 19'h08123;
        model[1] = 19'h10456;
        model[2] = 19'h18789;
        model[3] = 19'h7FFFF;
    endtask

    function automatic logic [DATA_W-1:0] expect_word(input logic [ADDR_W-1:0] a);
        if (int'(a) >= DEPTH) return '0;
        return model[a];
    endfunction

    task automatic read_check(input string tag, input logic [ADDR_W-1:0] a);
        pc = a;
        #1;
        check_eq(tag, instruction, expect_word(a));
    endtask

    // One write attempt across a single rising edge; model follows the write rules.
    task automatic do_write(input logic en, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        @(negedge clk);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        if (en && rst_n === 1'b1 && int'(a) < DEPTH) model[a] = d;
        #1;
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        pc      = 8'd3;
        model_boot();

        // Reset pulse; boot image must be visible while reset is still low.
        #3 rst_n = 1'b0;
        #1 check_eq("boot_during_reset", instruction, 19'h7FFFF);
        #19 rst_n = 1'b1;

        pc = 8'd0;
        #20 check_eq("boot_pc0", instruction, 19'h08123);
        read_check("boot_pc1", 8'd1);
        read_check("boot_pc2", 8'd2);
        read_check("boot_pc3", 8'd3);
        read_check("boot_pc4", 8'd4);
        read_check("boot_pcFF", 8'hFF);

        // Combinational sweep inside one half period, no clock edge in between.
        @(negedge clk);
        for (int i = 0; i < 4; i++) read_check("sweep", 8'(i));

        do_write(1'b1, 8'h10, 19'h2ABCD);
        read_check("load_10", 8'h10);
        check_eq("load_10_const", instruction, 19'h2ABCD);
        read_check("load_0F", 8'h0F);
        read_check("load_11", 8'h11);

        // Writes while reset is held must be dropped.
        @(negedge clk);
        rst_n = 1'b0;
        model_boot();
        do_write(1'b1, 8'h00, 19'h55555);
        do_write(1'b1, 8'h00, 19'h55555);
        @(negedge clk);
        rst_n = 1'b1;
        read_check("wr_in_reset", 8'h00);
        check_eq("wr_in_reset_const", instruction, 19'h08123);

        // Asynchronous reset between edges restores the boot word at once.
        do_write(1'b1, 8'h01, 19'h12345);
        read_check("pre_midreset", 8'h01);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_boot();
        pc = 8'h01;
        #1 check_eq("midreset_pc1", instruction, 19'h10456);
        @(negedge clk);
        rst_n = 1'b1;

        // Read-during-write on the same address.
        pc = 8'h20;
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 8'h20;
        wr_data = 19'h00F0F;
        #1 check_eq("rdw_before", instruction, 19'h00000);
        @(posedge clk);
        model[8'h20] = 19'h00F0F;
        #1 check_eq("rdw_after", instruction, 19'h00F0F);
        wr_en = 1'b0;

        // Randomized mix of writes (some disabled), reads and reset pulses.
        repeat (400) begin
            int op;
            op = $urandom_range(0, 19);
            if (op < 9) begin
                do_write($urandom_range(0, 3) != 0, 8'($urandom), 19'($urandom));
            end else if (op < 18) begin
                read_check("rand_read", 8'($urandom));
            end else begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                model_boot();
                read_check("rand_reset", 8'($urandom_range(0, 5)));
                do_write(1'b1, 8'($urandom_range(0, 5)), 19'($urandom));
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        for (int i = 0; i < DEPTH; i++) read_check("final_sweep", 8'(i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
